llrb_replay_buffer: RTL and testbench
=====================================

LLRB_REPLAY_BUFFER -- requirements
Module: llrb_replay_buffer

Interface
REQ-001 SHALL have parameter FLIT_W, default 528, meaning flit width incl. CRC.
REQ-002 SHALL have parameter DEPTH, default 64, meaning entry count; power of 2, DEPTH <= 2^(SEQ_W-1).
REQ-003 SHALL have parameter SEQ_W, default 8, meaning sequence-number width; PTR_W = clog2(DEPTH).
REQ-004 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port i_rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port controller_wr_en  in  1  write request.
REQ-007 SHALL have port crc_generator_flit_w_crc  in  FLIT_W  flit to store.
REQ-008 SHALL have port i_ack_valid  in  1  ack strobe.
REQ-009 SHALL have port i_ack_cnt  in  PTR_W+1  flits freed by this ack.
REQ-010 SHALL have port i_replay_req  in  1  replay start strobe.
REQ-011 SHALL have port i_replay_eseq  in  SEQ_W  first sequence to replay.
REQ-012 SHALL have port i_replay_ready  in  1  consumer accepts replay flit.
REQ-013 SHALL have port o_replay_valid  out  1  replay flit valid.
REQ-014 SHALL have port o_replay_flit  out  FLIT_W  flit at read slot.
REQ-015 SHALL have port o_replay_busy  out  1  FSM in REPLAY.
REQ-016 SHALL have port o_replay_done  out  1  one-cycle pulse at replay end.
REQ-017 SHALL have ports o_full, o_empty  out  1 each  occupancy flags.
REQ-018 SHALL have port o_occupancy  out  PTR_W+1  unacked entries.
REQ-019 SHALL have port o_wr_seq  out  SEQ_W  sequence of next write.
REQ-020 SHALL have ports o_wr_ovf, o_replay_err  out  1 each  one-cycle error pulses.

Function
REQ-021 Write: controller_wr_en && !o_full SHALL store flit at slot o_wr_seq[PTR_W-1:0], increment o_wr_seq (mod 2^SEQ_W) and occupancy next cycle.
REQ-022 controller_wr_en while o_full SHALL drop the flit, leave state unchanged, pulse o_wr_ovf next cycle.
REQ-023 Ack: i_ack_valid SHALL reduce occupancy by min(i_ack_cnt, occupancy); write and ack in same cycle SHALL both apply (net occupancy = occ + wr - ack).
REQ-024 o_full = (occupancy == DEPTH); o_empty = (occupancy == 0); both combinational from registered occupancy.
REQ-025 FSM states IDLE, REPLAY; IDLE->REPLAY on accepted i_replay_req; REPLAY->IDLE when remaining count reaches 0.
REQ-026 On accepted i_replay_req: read slot <= i_replay_eseq[PTR_W-1:0]; remaining <= (o_wr_seq - i_replay_eseq) mod 2^SEQ_W.
REQ-027 Remaining == 0 at acceptance SHALL enter no REPLAY; o_replay_done SHALL pulse next cycle.
REQ-028 In REPLAY: o_replay_valid = (remaining != 0); o_replay_flit = storage[read slot], zero-latency combinational read.
REQ-029 o_replay_valid && i_replay_ready SHALL advance read slot (wrap DEPTH-1->0) and decrement remaining; transfer of last flit SHALL pulse o_replay_done next cycle.
REQ-030 Write accepted during REPLAY SHALL increment remaining (same-cycle write and transfer: remaining unchanged).
REQ-031 i_replay_req during REPLAY SHALL restart replay per REQ-026; restart wins over same-cycle transfer.
REQ-032 Ack during REPLAY SHALL not alter read slot or remaining.
REQ-033 o_replay_valid SHALL be 0 in IDLE; o_replay_flit undefined-but-stable when not valid.

Reset
REQ-034 i_rst SHALL clear o_wr_seq, occupancy, read slot, remaining, FSM to IDLE; outputs 0 except o_empty=1.
REQ-035 Storage array SHALL NOT be reset; reset mid-replay SHALL abort with no o_replay_done pulse.

Configuration
REQ-036 Macro LLRB_REPLAY_ERR_CHK_EN defined: i_replay_req whose remaining > occupancy SHALL be ignored (state unchanged) and pulse o_replay_err next cycle.
REQ-037 Macro undefined: no window check, every i_replay_req accepted, o_replay_err tied 0.

Structure
REQ-038 Package llrb_pkg SHALL hold FSM state enum (IDLE, REPLAY) and default FLIT_W/DEPTH/SEQ_W constants.
REQ-039 Storage SHALL be sub-module llrb_mem: 1 write port, 1 combinational read port, no reset.

Verification
REQ-040 Reset, 64 writes, 65th write -> o_full=1, occupancy=64, o_wr_ovf pulses, o_wr_seq=64.
REQ-041 10 writes, ack cnt=4 with same-cycle write -> occupancy=7; ack cnt=20 -> occupancy=0, o_empty=1.
REQ-042 Seqs 0..9 written, acked 3, replay eseq=5, ready=1 -> flits 5..9 in 5 consecutive cycles, o_replay_done once.
REQ-043 Wrap: o_wr_seq=250, 8 writes (seq 250..1), replay eseq=254, ready toggling -> flits 254,255,0,1 in order; write during replay -> extra flit 2 replayed.
REQ-044 Replay eseq=3 mid-replay of eseq=7 -> restart delivers from 3; reset mid-replay -> busy=0, no done.
REQ-045 LLRB_REPLAY_ERR_CHK_EN: occupancy 4, o_wr_seq=20, replay eseq=10 -> o_replay_err pulse, stays IDLE; undefined -> replay accepted, err=0.

Source files
------------

// File: rtl/llrb_pkg.sv
// rtl/llrb_pkg.sv - shared constants and FSM state type for the link-layer replay buffer
package llrb_pkg;

  localparam int LLRB_FLIT_W = 528;
  localparam int LLRB_DEPTH  = 64;
  localparam int LLRB_SEQ_W  = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    REPLAY = 1'b1
  } llrb_state_e;

endpackage

// File: rtl/llrb_mem.sv
// rtl/llrb_mem.sv - flit storage: one write port, one zero-latency combinational read port, no reset
module llrb_mem #(
  parameter  int W     = 528,
  parameter  int DEPTH = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_addr,
  input  logic [W-1:0]     i_wr_data,
  input  logic [PTR_W-1:0] i_rd_addr,
  output logic [W-1:0]     o_rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/llrb_replay_buffer.sv
// rtl/llrb_replay_buffer.sv - retry buffer with ack-based freeing and sequence-addressed replay
// Optional replay window check enabled by defining LLRB_REPLAY_ERR_CHK_EN.
module llrb_replay_buffer
  import llrb_pkg::*;
#(
  parameter  int FLIT_W = LLRB_FLIT_W,
  parameter  int DEPTH  = LLRB_DEPTH,
  parameter  int SEQ_W  = LLRB_SEQ_W,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              controller_wr_en,
  input  logic [FLIT_W-1:0] crc_generator_flit_w_crc,
  input  logic              i_ack_valid,
  input  logic [PTR_W:0]    i_ack_cnt,
  input  logic              i_replay_req,
  input  logic [SEQ_W-1:0]  i_replay_eseq,
  input  logic              i_replay_ready,
  output logic              o_replay_valid,
  output logic [FLIT_W-1:0] o_replay_flit,
  output logic              o_replay_busy,
  output logic              o_replay_done,
  output logic              o_full,
  output logic              o_empty,
  output logic [PTR_W:0]    o_occupancy,
  output logic [SEQ_W-1:0]  o_wr_seq,
  output logic              o_wr_ovf,
  output logic              o_replay_err
);

  llrb_state_e      state_q, state_d;
  logic [SEQ_W-1:0] wr_seq_q, wr_seq_d;
  logic [SEQ_W-1:0] rem_q, rem_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic [PTR_W-1:0] rd_slot_q, rd_slot_d;
  logic             done_q, done_d;
  logic             wr_ovf_q, wr_ovf_d;
  logic             err_q, err_d;

  logic             full;
  logic             wr_acc;
  logic             xfer;
  logic             win_ok;
  logic [SEQ_W-1:0] req_rem;
  logic [PTR_W:0]   ack_amt;

  assign full    = (occ_q == (PTR_W+1)'(DEPTH));
  assign wr_acc  = controller_wr_en && !full;
  assign req_rem = wr_seq_q - i_replay_eseq;
  assign xfer    = o_replay_valid && i_replay_ready;

  llrb_mem #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (wr_acc),
    .i_wr_addr (wr_seq_q[PTR_W-1:0]),
    .i_wr_data (crc_generator_flit_w_crc),
    .i_rd_addr (rd_slot_q),
    .o_rd_data (o_replay_flit)
  );

  // Window check: a replay may not reach further back than what is still unacked.
  always_comb begin
`ifdef LLRB_REPLAY_ERR_CHK_EN
    win_ok = ({1'b0, req_rem} <= {{(SEQ_W-PTR_W){1'b0}}, occ_q});
`else
    win_ok = 1'b1;
`endif
  end

  always_comb begin
    ack_amt = '0;
    if (i_ack_valid) begin
      ack_amt = (i_ack_cnt > occ_q) ? occ_q : i_ack_cnt;
    end
    occ_d    = occ_q + (PTR_W+1)'(wr_acc) - ack_amt;
    wr_seq_d = wr_seq_q + SEQ_W'(wr_acc);
    wr_ovf_d = controller_wr_en && full;
    err_d    = i_replay_req && !win_ok;
  end

  always_comb begin
    state_d   = state_q;
    rd_slot_d = rd_slot_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    if (i_replay_req && win_ok) begin
      // A (re)start overrides any same-cycle transfer.
      if (req_rem == '0) begin
        state_d = IDLE;
        rem_d   = '0;
        done_d  = 1'b1;
      end else begin
        state_d   = REPLAY;
        rd_slot_d = i_replay_eseq[PTR_W-1:0];
        rem_d     = req_rem;
      end
    end else if (state_q == REPLAY) begin
      if (xfer) begin
        rd_slot_d = rd_slot_q + PTR_W'(1);
      end
      rem_d = rem_q - SEQ_W'(xfer) + SEQ_W'(wr_acc);
      if (xfer && !wr_acc && (rem_q == SEQ_W'(1))) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      wr_seq_q  <= '0;
      rem_q     <= '0;
      occ_q     <= '0;
      rd_slot_q <= '0;
      done_q    <= 1'b0;
      wr_ovf_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_seq_q  <= wr_seq_d;
      rem_q     <= rem_d;
      occ_q     <= occ_d;
      rd_slot_q <= rd_slot_d;
      done_q    <= done_d;
      wr_ovf_q  <= wr_ovf_d;
      err_q     <= err_d;
    end
  end

  assign o_replay_busy  = (state_q == REPLAY);
  assign o_replay_valid = (state_q == REPLAY) && (rem_q != '0);
  assign o_replay_done  = done_q;
  assign o_full         = full;
  assign o_empty        = (occ_q == '0);
  assign o_occupancy    = occ_q;
  assign o_wr_seq       = wr_seq_q;
  assign o_wr_ovf       = wr_ovf_q;
  assign o_replay_err   = err_q;

endmodule

// File: tb/tb_llrb_replay_buffer.sv
// tb/tb_llrb_replay_buffer.sv - scoreboard bench for llrb_replay_buffer
module tb_llrb_replay_buffer;

  localparam int FLIT_W = 528;
  localparam int DEPTH  = 64;
  localparam int SEQ_W  = 8;
  localparam int PTR_W  = 6;

  logic              i_clk;
  logic              i_rst;
  logic              controller_wr_en;
  logic [FLIT_W-1:0] crc_generator_flit_w_crc;
  logic              i_ack_valid;
  logic [PTR_W:0]    i_ack_cnt;
  logic              i_replay_req;
  logic [SEQ_W-1:0]  i_replay_eseq;
  logic              i_replay_ready;
  logic              o_replay_valid;
  logic [FLIT_W-1:0] o_replay_flit;
  logic              o_replay_busy;
  logic              o_replay_done;
  logic              o_full;
  logic              o_empty;
  logic [PTR_W:0]    o_occupancy;
  logic [SEQ_W-1:0]  o_wr_seq;
  logic              o_wr_ovf;
  logic              o_replay_err;

  llrb_replay_buffer #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH),
    .SEQ_W  (SEQ_W)
  ) dut (
    .i_clk                    (i_clk),
    .i_rst                    (i_rst),
    .controller_wr_en         (controller_wr_en),
    .crc_generator_flit_w_crc (crc_generator_flit_w_crc),
    .i_ack_valid              (i_ack_valid),
    .i_ack_cnt                (i_ack_cnt),
    .i_replay_req             (i_replay_req),
    .i_replay_eseq            (i_replay_eseq),
    .i_replay_ready           (i_replay_ready),
    .o_replay_valid           (o_replay_valid),
    .o_replay_flit            (o_replay_flit),
    .o_replay_busy            (o_replay_busy),
    .o_replay_done            (o_replay_done),
    .o_full                   (o_full),
    .o_empty                  (o_empty),
    .o_occupancy              (o_occupancy),
    .o_wr_seq                 (o_wr_seq),
    .o_wr_ovf                 (o_wr_ovf),
    .o_replay_err             (o_replay_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;

  logic [FLIT_W-1:0] model_mem [DEPTH];
  logic [FLIT_W-1:0] exp_q [$];
  int                m_occ;
  int                m_wr_seq;
  bit                replay_active;

  task automatic check(input string tag, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && o_replay_valid && i_replay_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) check("replay_unexpected_flit", 1, 0);
      else check("replay_flit", o_replay_flit, exp_q.pop_front());
    end
    if (!i_rst && o_replay_done) done_cnt++;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_strobes();
    controller_wr_en = 1'b0;
    i_ack_valid      = 1'b0;
    i_replay_req     = 1'b0;
  endtask

  task automatic do_reset();
    clear_strobes();
    i_replay_ready = 1'b0;
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    m_occ = 0;
    m_wr_seq = 0;
    exp_q.delete();
    replay_active = 1'b0;
  endtask

  task automatic stage_write();
    logic [FLIT_W-1:0] f;
    for (int i = 0; i < FLIT_W; i += 16) f[i +: 16] = 16'($urandom);
    controller_wr_en = 1'b1;
    crc_generator_flit_w_crc = f;
    if (m_occ < DEPTH) begin
      model_mem[m_wr_seq % DEPTH] = f;
      m_wr_seq = (m_wr_seq + 1) % 256;
      m_occ++;
      if (replay_active) exp_q.push_back(f);
    end
  endtask

  task automatic drive_cycle(input bit wr, input bit ack, input int cnt);
    int a;
    a = 0;
    if (ack) begin
      i_ack_valid = 1'b1;
      i_ack_cnt   = (PTR_W+1)'(cnt);
      a = (cnt < m_occ) ? cnt : m_occ;
    end
    if (wr) stage_write();
    m_occ -= a;
    tick();
    clear_strobes();
  endtask

  task automatic replay(input int eseq);
    int rem;
    bit ok;
    rem = (m_wr_seq - eseq) & 255;
    ok = 1'b1;
`ifdef LLRB_REPLAY_ERR_CHK_EN
    ok = (rem <= m_occ);
`endif
    i_replay_req  = 1'b1;
    i_replay_eseq = SEQ_W'(eseq);
    if (ok) begin
      exp_q.delete();
      for (int k = 0; k < rem; k++) exp_q.push_back(model_mem[(eseq + k) % DEPTH]);
      replay_active = (rem != 0);
    end
    tick();
    clear_strobes();
  endtask

  task automatic wait_done(input int max, output int cycles, output bit found);
    found = 1'b0;
    cycles = 0;
    for (int c = 0; c < max; c++) begin
      @(negedge i_clk);
      cycles++;
      if (o_replay_done) begin
        found = 1'b1;
        break;
      end
    end
    @(posedge i_clk);
    #1;
    replay_active = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  found;
    int  d0;
    int  x0;

    i_rst = 1'b1;
    controller_wr_en = 1'b0;
    crc_generator_flit_w_crc = '0;
    i_ack_valid = 1'b0;
    i_ack_cnt = '0;
    i_replay_req = 1'b0;
    i_replay_eseq = '0;
    i_replay_ready = 1'b0;

    do_reset();
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_occ", o_occupancy, 0);
    check("rst_wr_seq", o_wr_seq, 0);
    check("rst_busy", o_replay_busy, 0);
    check("rst_valid", o_replay_valid, 0);
    check("rst_done", o_replay_done, 0);
    check("rst_ovf", o_wr_ovf, 0);
    check("rst_err", o_replay_err, 0);

    // Fill to full, then overflow.
    repeat (64) drive_cycle(1, 0, 0);
    check("fill_full", o_full, 1);
    check("fill_occ", o_occupancy, 64);
    check("fill_wr_seq", o_wr_seq, 64);
    check("fill_ovf_quiet", o_wr_ovf, 0);
    drive_cycle(1, 0, 0);
    check("ovf_pulse", o_wr_ovf, 1);
    check("ovf_occ", o_occupancy, 64);
    check("ovf_wr_seq", o_wr_seq, m_wr_seq);
    tick();
    check("ovf_one_cycle", o_wr_ovf, 0);

    // Ack with same-cycle write, then over-ack.
    do_reset();
    repeat (10) drive_cycle(1, 0, 0);
    drive_cycle(1, 1, 4);
    check("ack_wr_occ", o_occupancy, 7);
    drive_cycle(0, 1, 20);
    check("overack_occ", o_occupancy, 0);
    check("overack_empty", o_empty, 1);

    // Basic replay of 5..9 with ready held high.
    do_reset();
    repeat (10) drive_cycle(1, 0, 0);
    drive_cycle(0, 1, 3);
    check("pre_replay_occ", o_occupancy, 7);
    i_replay_ready = 1'b1;
    d0 = done_cnt;
    x0 = xfer_cnt;
    replay(5);
    check("replay_busy", o_replay_busy, 1);
    check("replay_valid", o_replay_valid, 1);
    wait_done(20, cyc, found);
    check("replay_done_seen", found, 1);
    check("replay_cycles", cyc, 6);
    check("replay_xfers", xfer_cnt - x0, 5);
    check("replay_sb_empty", exp_q.size(), 0);
    check("replay_idle", o_replay_busy, 0);
    repeat (3) tick();
    check("replay_done_once", done_cnt - d0, 1);
    check("idle_valid", o_replay_valid, 0);

    // Replay from the write pointer: nothing to send, done next cycle.
    replay(m_wr_seq);
    check("zero_rem_done", o_replay_done, 1);
    check("zero_rem_busy", o_replay_busy, 0);

    // Sequence wrap with toggling ready and a write mid-replay.
    do_reset();
    repeat (250) drive_cycle(1, 1, 1);
    drive_cycle(0, 1, 1);
    check("wrap_pre_seq", o_wr_seq, 250);
    repeat (8) drive_cycle(1, 0, 0);
    check("wrap_seq", o_wr_seq, 2);
    check("wrap_occ", o_occupancy, 8);
    d0 = done_cnt;
    x0 = xfer_cnt;
    replay(254);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      i_replay_ready = c[0];
      if (c == 3) stage_write();
      @(negedge i_clk);
      found = o_replay_done;
      @(posedge i_clk);
      #1;
      controller_wr_en = 1'b0;
    end
    replay_active = 1'b0;
    check("wrap_done_seen", found, 1);
    check("wrap_xfers", xfer_cnt - x0, 5);
    check("wrap_done_cnt", done_cnt - d0, 1);
    check("wrap_sb_empty", exp_q.size(), 0);
    check("wrap_wr_seq", o_wr_seq, 3);

    // Restart mid-replay.
    do_reset();
    repeat (10) drive_cycle(1, 0, 0);
    d0 = done_cnt;
    x0 = xfer_cnt;
    replay(7);
    check("restart_busy", o_replay_busy, 1);
    i_replay_ready = 1'b1;
    tick();
    i_replay_ready = 1'b0;
    replay(3);
    check("restart_busy2", o_replay_busy, 1);
    i_replay_ready = 1'b1;
    wait_done(30, cyc, found);
    check("restart_done_seen", found, 1);
    check("restart_xfers", xfer_cnt - x0, 8);
    check("restart_done_cnt", done_cnt - d0, 1);
    check("restart_sb_empty", exp_q.size(), 0);

    // Reset in the middle of a replay.
    i_replay_ready = 1'b0;
    replay(2);
    check("abort_busy", o_replay_busy, 1);
    d0 = done_cnt;
    i_rst = 1'b1;
    tick();
    check("abort_busy_clr", o_replay_busy, 0);
    check("abort_valid_clr", o_replay_valid, 0);
    i_rst = 1'b0;
    m_occ = 0;
    m_wr_seq = 0;
    exp_q.delete();
    replay_active = 1'b0;
    i_replay_ready = 1'b1;
    repeat (4) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_wr_seq", o_wr_seq, 0);

    // Replay window check.
    do_reset();
    repeat (20) drive_cycle(1, 0, 0);
    drive_cycle(0, 1, 16);
    check("win_occ", o_occupancy, 4);
    check("win_wr_seq", o_wr_seq, 20);
    replay(10);
`ifdef LLRB_REPLAY_ERR_CHK_EN
    check("win_err_pulse", o_replay_err, 1);
    check("win_err_idle", o_replay_busy, 0);
    tick();
    check("win_err_one_cycle", o_replay_err, 0);
`else
    check("win_accept_busy", o_replay_busy, 1);
    check("win_accept_err", o_replay_err, 0);
    i_replay_ready = 1'b1;
    wait_done(30, cyc, found);
    check("win_accept_done", found, 1);
`endif
    check("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
